// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: shared stage encodings and RV32 major opcodes for the stage sequencer
package stage_sequencer_pkg;
   localparam int STAGE_WIDTH = 3;
   typedef enum logic [STAGE_WIDTH-1:0] {
      S_FETCH           = 3'd0,
      S_DECODE          = 3'd1,
      S_EXECUTE         = 3'd2,
      S_MEMORY          = 3'd3,
      S_REGISTER_UPDATE = 3'd4,
      S_HALT            = 3'd5
   } stage_t;
   localparam logic [6:0] OP_LUI         = 7'b0110111;
   localparam logic [6:0] OP_AUIPC       = 7'b0010111;
   localparam logic [6:0] OP_JAL         = 7'b1101111;
   localparam logic [6:0] OP_JALR        = 7'b1100111;
   localparam logic [6:0] OP_BRANCH      = 7'b1100011;
   localparam logic [6:0] OP_LOAD        = 7'b0000011;
   localparam logic [6:0] OP_STORE       = 7'b0100011;
   localparam logic [6:0] OP_ALU_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_ALU_OP_REGS = 7'b0110011;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: flags legal major opcodes and the ones that need a data memory access
module opcode_classifier
   import stage_sequencer_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       legal,
   output logic       is_mem
);
   assign is_mem = opcode inside {OP_LOAD, OP_STORE};
   assign legal  = is_mem || (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                             OP_ALU_OP_IMM, OP_ALU_OP_REGS});
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction stage FSM; define STAGE_SKIP_EN to bypass MEMORY for non-memory ops
module stage_sequencer
   import stage_sequencer_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [6:0]             opcode,
   input  logic                   mem_ready,
   output logic [STAGE_WIDTH-1:0] stage,
   output logic                   mem_req,
   output logic                   pc_write_enable,
   output logic                   halted,
   output logic [31:0]            retired
);
   stage_t state;
   logic   legal, is_mem;
   opcode_classifier u_classifier (.opcode(opcode), .legal(legal), .is_mem(is_mem));
   assign stage           = state;
   assign mem_req         = (state == S_FETCH) || (state == S_MEMORY && is_mem);
   assign pc_write_enable = (state == S_REGISTER_UPDATE);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= S_FETCH;
         halted  <= 1'b0;
         retired <= '0;
      end else begin
         case (state)
            S_FETCH:           state <= mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               state  <= legal ? S_EXECUTE : S_HALT;
               halted <= ~legal;
            end
`ifdef STAGE_SKIP_EN
            S_EXECUTE:         state <= is_mem ? S_MEMORY : S_REGISTER_UPDATE;
`else
            S_EXECUTE:         state <= S_MEMORY;
`endif
            S_MEMORY:          state <= (!is_mem || mem_ready) ? S_REGISTER_UPDATE : S_MEMORY;
            S_REGISTER_UPDATE: begin
               state   <= S_FETCH;
               retired <= retired + 32'd1;
            end
            default:           state <= S_HALT;
         endcase
      end
endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port opcode  input  7  instruction opcode; stable from DECODE until the next FETCH.
REQ-004 SHALL have port mem_ready  input  1  memory completion strobe for the current request.
REQ-005 SHALL have port stage  output  `STAGE_WIDTH  current stage, registered.
REQ-006 SHALL have port mem_req  output  1  memory request; high in FETCH, and in MEMORY for LOAD/STORE, until accepted.
REQ-007 SHALL have port pc_write_enable  output  1  one-cycle pulse in REGISTER_UPDATE.
REQ-008 SHALL have port halted  output  1  sticky illegal-opcode flag.
REQ-009 SHALL have port retired  output  32  count of completed instructions.

Function
REQ-010 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, REGISTER_UPDATE, HALT; stage reflects the state directly.
REQ-011 FETCH SHALL assert mem_req and hold it until a cycle with mem_ready=1, then move to DECODE; mem_ready=0 keeps FETCH with no limit.
REQ-012 DECODE SHALL last exactly one cycle; legal opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_OP_IMM, ALU_OP_REGS) -> EXECUTE, otherwise -> HALT.
REQ-013 EXECUTE SHALL last exactly one cycle; next state per REQ-026/REQ-027.
REQ-014 MEMORY with LOAD/STORE SHALL assert mem_req until mem_ready=1, then move to REGISTER_UPDATE.
REQ-015 MEMORY with any other opcode SHALL last one cycle with mem_req=0.
REQ-016 REGISTER_UPDATE SHALL last one cycle, assert pc_write_enable, increment retired, then return to FETCH.
REQ-017 mem_ready SHALL be ignored in every cycle where mem_req=0.
REQ-018 mem_req and pc_write_enable SHALL be combinational decodes of the registered state and opcode, glitch-free relative to clk.
REQ-019 retired SHALL wrap from 0xFFFFFFFF to 0 without any flag.
REQ-020 HALT SHALL be absorbing until reset: halted=1, mem_req=0, pc_write_enable=0, retired frozen.
REQ-021 A mem_ready pulse coincident with state entry SHALL complete the request that same cycle (minimum one cycle per memory stage).

Reset
REQ-022 Assertion of reset SHALL force FETCH, halted=0, retired=0 immediately, independent of clk.
REQ-023 Reset during a pending memory request SHALL abandon it; the first cycle after release SHALL be FETCH with mem_req=1.
REQ-024 Reset SHALL be the only exit from HALT.

Configuration
REQ-025 Macro STAGE_SKIP_EN SHALL select memory-stage skipping.
REQ-026 With STAGE_SKIP_EN defined, EXECUTE SHALL go to MEMORY only for LOAD/STORE and directly to REGISTER_UPDATE otherwise (4 cycles for ALU with single-cycle fetch).
REQ-027 Without STAGE_SKIP_EN, EXECUTE SHALL always go to MEMORY (5 cycles for ALU with single-cycle fetch).

Structure
REQ-028 Stage encodings (`STAGE_FETCH ... `STAGE_HALT, `STAGE_WIDTH) and opcode constants SHALL live in the shared arch defines file, not in this module.
REQ-029 Opcode legality and LOAD/STORE classification SHALL be a sub-module opcode_classifier (outputs legal, is_mem).
REQ-030 The block SHALL contain one state register, one halted flag and one 32-bit counter, and no other storage.

Verification
REQ-031 Reset release, mem_ready tied 1, opcode=ALU_OP_REGS -> stage sequence FETCH,DECODE,EXECUTE,REGISTER_UPDATE,FETCH (skip on) or with MEMORY inserted (skip off); retired=1 after first REGISTER_UPDATE.
REQ-032 LOAD with mem_ready low 3 cycles in MEMORY -> mem_req high 4 cycles, stage MEMORY 4 cycles, one pc_write_enable pulse.
REQ-033 opcode=0x00 at DECODE -> HALT next cycle, halted=1, mem_req=0 for 20 further cycles, retired unchanged.
REQ-034 Reset asserted mid-FETCH-wait with mem_ready=0 -> stage=FETCH and retired=0 before the next clk edge; mem_req=1 after release.
REQ-035 retired preloaded near 0xFFFFFFFF via 1 forced retirement -> next REGISTER_UPDATE yields retired=0.
REQ-036 mem_ready pulses in DECODE/EXECUTE -> no state change beyond normal sequencing, no extra retirements.
